// File: rtl/seq_dpa.sv
// Sequential chunked add/sub: N/W cycles from accept to out_valid, result held until out_ready.
// in_ready only while idle; optional accumulator feedback with SEQ_DPA_ACCUM_EN.
module seq_dpa #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  input  logic         signed_en,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SEQ_DPA_ACCUM_EN
  input  logic         acc_en,
  input  logic         acc_clr,
`endif
  output logic [N-1:0] final_sum,
  output logic         cout,
  output logic         negative_flag,
  output logic         overflow_flag,
  output logic         zero_flag
);

  localparam int NCH = N / W;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_q, b_q, raw_sum;
  logic           carry_q, c_msb_q, sub_q, signed_q;
  logic [KW-1:0]  k_q;
  logic           accept, handshake, last_chunk;
  logic [N-1:0]   a_sel;
  logic [W-1:0]   a_ch, b_ch;
  logic [W:0]     ch_sum;
  logic [W-1:0]   low_sum;
  int             base;

  assign accept     = in_valid && in_ready;
  assign handshake  = out_valid && out_ready;
  assign last_chunk = (k_q == KW'(NCH - 1));

`ifdef SEQ_DPA_ACCUM_EN
  logic [N-1:0] acc_q;

  assign a_sel = acc_en ? acc_q : a;

  always_ff @(posedge clk) begin
    if (rst || acc_clr)
      acc_q <= '0;
    else if (handshake)
      acc_q <= raw_sum;
  end
`else
  assign a_sel = a;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign base = int'(k_q) * W;
  assign a_ch = a_q[base +: W];
  assign b_ch = b_q[base +: W];
  assign ch_sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{W{1'b0}}, carry_q};
  // Same chunk without its top bit: bit W-1 is the carry into that top bit.
  assign low_sum = {1'b0, a_ch[W-2:0]} + {1'b0, b_ch[W-2:0]} + {{(W-1){1'b0}}, carry_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      raw_sum  <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      sub_q    <= 1'b0;
      signed_q <= 1'b0;
      k_q      <= '0;
    end else if (accept) begin
      a_q      <= a_sel;
      b_q      <= sub ? ~b : b;
      carry_q  <= sub ? 1'b1 : cin;
      sub_q    <= sub;
      signed_q <= signed_en;
      k_q      <= '0;
    end else if (state == RUN) begin
      raw_sum[base +: W] <= ch_sum[W-1:0];
      carry_q            <= ch_sum[W];
      if (last_chunk) begin
        c_msb_q <= low_sum[W-1];
        k_q     <= '0;
      end else begin
        k_q     <= k_q + 1'b1;
      end
    end
  end

  assign final_sum     = (signed_q && raw_sum[N-1]) ? (~raw_sum + N'(1)) : raw_sum;
  assign cout          = carry_q;
  assign negative_flag = signed_q & raw_sum[N-1];
  assign overflow_flag = signed_q ? (c_msb_q ^ carry_q) : (sub_q ? ~carry_q : carry_q);
  assign zero_flag     = (final_sum == '0);

endmodule
